// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared constants for the register file write-back port.
//            - Write-destination mode encodings (wr_sel).
//            - Default special-register indices and the stack-pointer
//              reset value.
// Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

  // Write-destination mode encodings
  localparam logic [1:0] WR_SEL_RT = 2'b00;
  localparam logic [1:0] WR_SEL_SP = 2'b01;
  localparam logic [1:0] WR_SEL_RA = 2'b10;
  localparam logic [1:0] WR_SEL_RD = 2'b11;

  // Default special-register placement
  localparam int DEF_SP_INDEX = 29;
  localparam int DEF_RA_INDEX = 31;
  localparam int DEF_SP_RESET = 227;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/wr_dest_decode.sv
`default_nettype none
// ============================================================================
// Module   : wr_dest_decode
// Purpose  : Combinational write-destination selector. Maps the write mode
//            and instruction register fields onto a destination index and
//            flags whether that destination may actually be written.
// Ports    : wr_sel  [1:0]        in   destination mode (rt / SP / RA / rd)
//            rt_addr [ADDR_W-1:0] in   instruction rt field
//            rd_addr [ADDR_W-1:0] in   instruction rd field
//            dest    [ADDR_W-1:0] out  decoded destination index
//            dest_ok              out  destination is nonzero and implemented
// Revision : 1.0  initial release
// ============================================================================
module wr_dest_decode
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32,
  parameter int SP_INDEX = DEF_SP_INDEX,
  parameter int RA_INDEX = DEF_RA_INDEX
) (
  input  logic [1:0]        wr_sel,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] dest,
  output logic              dest_ok
);

  always_comb begin
    dest = '0;
    case (wr_sel)
      WR_SEL_RT: dest = rt_addr;
      WR_SEL_SP: dest = ADDR_W'(SP_INDEX);
      WR_SEL_RA: dest = ADDR_W'(RA_INDEX);
      WR_SEL_RD: dest = rd_addr;
      default:   dest = '0;
    endcase
  end

  // Register 0 is hard-wired and indices past the implemented count do not
  // exist, so neither is a legal write target.
  always_comb begin
    dest_ok = (dest != '0) && (int'(dest) < NUM_REGS);
  end

endmodule : wr_dest_decode
`default_nettype wire

// File: rtl/regfile_wb_port.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_port
// Purpose  : Parametrised register file with a write-destination selector
//            and a one-entry registered write-back stage. Writes are
//            captured into the stage, committed to the array one edge later,
//            and forwarded to both read ports while pending.
// Ports    : clk       in   rising-edge clock
//            reset     in   synchronous active-high reset
//            reg_write in   request a write this cycle
//            wr_sel    in   destination mode (00 rt, 01 SP, 10 RA, 11 rd)
//            rt_addr   in   instruction rt field
//            rd_addr   in   instruction rd field
//            wr_data   in   write data
//            rs_raddr  in   read port A address
//            rt_raddr  in   read port B address
//            rs_data   out  read port A data (combinational)
//            rt_data   out  read port B data (combinational)
//            wb_valid  out  write-back stage holds a pending commit
//            wb_addr   out  destination of the pending commit
// Revision : 1.0  initial release
// ============================================================================
module regfile_wb_port
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int SP_INDEX = DEF_SP_INDEX,
  parameter int RA_INDEX = DEF_RA_INDEX,
  parameter int SP_RESET = DEF_SP_RESET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [1:0]        wr_sel,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rs_raddr,
  input  logic [ADDR_W-1:0] rt_raddr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_addr
);

  logic [ADDR_W-1:0] w_dest;
  logic              w_dest_ok;

  logic              r_wb_valid;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  wr_dest_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .SP_INDEX (SP_INDEX),
    .RA_INDEX (RA_INDEX)
  ) u_dest (
    .wr_sel  (wr_sel),
    .rt_addr (rt_addr),
    .rd_addr (rd_addr),
    .dest    (w_dest),
    .dest_ok (w_dest_ok)
  );

  // Write-back stage: reloads every cycle, so a capture and the commit of
  // the previous capture share one edge without stalling.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= reg_write && w_dest_ok;
      r_wb_addr  <= w_dest;
      r_wb_data  <= wr_data;
    end
  end

  // Register array. Entry 0 is only ever loaded with zero; commits start at
  // index 1 so it can never change.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= (i == SP_INDEX) ? DATA_W'(SP_RESET) : '0;
      end
    end else if (r_wb_valid) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (r_wb_addr == ADDR_W'(i)) begin
          r_regs[i] <= r_wb_data;
        end
      end
    end
  end

  // Read ports. Address 0 and unimplemented addresses fall through to zero.
  // A pending commit is forwarded; its address is never zero because the
  // stage refuses to capture register 0.
  always_comb begin
    rs_data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rs_raddr == ADDR_W'(i)) begin
        rs_data = r_regs[i];
      end
    end
    if (r_wb_valid && (rs_raddr == r_wb_addr)) begin
      rs_data = r_wb_data;
    end
  end

  always_comb begin
    rt_data = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (rt_raddr == ADDR_W'(i)) begin
        rt_data = r_regs[i];
      end
    end
    if (r_wb_valid && (rt_raddr == r_wb_addr)) begin
      rt_data = r_wb_data;
    end
  end

  assign wb_valid = r_wb_valid;
  assign wb_addr  = r_wb_addr;

endmodule : regfile_wb_port
`default_nettype wire

// File: tb/tb_regfile_wb_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_port
// Purpose  : Self-checking bench for regfile_wb_port. A reference model
//            holds the architecturally visible register contents (a write is
//            visible from the edge that captures it) plus the expected
//            write-back stage state.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_port;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [1:0]  wr_sel;
  logic [4:0]  rt_addr;
  logic [4:0]  rd_addr;
  logic [31:0] wr_data;
  logic [4:0]  rs_raddr;
  logic [4:0]  rt_raddr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        wb_valid;
  logic [4:0]  wb_addr;

  int checks;
  int failures;

  // Reference model state
  logic [31:0] mem [32];
  logic        exp_valid;
  logic [4:0]  exp_addr;

  regfile_wb_port dut (
    .clk       (clk),
    .reset     (reset),
    .reg_write (reg_write),
    .wr_sel    (wr_sel),
    .rt_addr   (rt_addr),
    .rd_addr   (rd_addr),
    .wr_data   (wr_data),
    .rs_raddr  (rs_raddr),
    .rt_raddr  (rt_raddr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    mem[29]   = 32'd227;
    exp_valid = 1'b0;
    exp_addr  = 5'd0;
  endtask

  // Apply the rules to the inputs sampled at a rising edge.
  task automatic model_edge();
    int dest;
    if (reset) begin
      model_reset();
    end else begin
      case (wr_sel)
        2'b00:   dest = int'(rt_addr);
        2'b01:   dest = 29;
        2'b10:   dest = 31;
        default: dest = int'(rd_addr);
      endcase
      if (reg_write && dest != 0 && dest < 32) begin
        mem[dest] = wr_data;
        exp_valid = 1'b1;
        exp_addr  = 5'(dest);
      end else begin
        exp_valid = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    reg_write = 1'b0;
    wr_sel    = 2'b00;
    rt_addr   = 5'd0;
    rd_addr   = 5'd0;
    wr_data   = 32'd0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    reg_write = 1'b1;           // reset must win over a write request
    wr_sel    = 2'b11;
    rd_addr   = 5'd4;
    wr_data   = 32'h1234_5678;
    tick();
    tick();
    reset = 1'b0;
    idle_inputs();
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_wb_valid: got %0b want 0", wb_valid);
    end
    checks++;
    if (wb_addr !== 5'd0) begin
      failures++;
      $display("FAIL reset_wb_addr: got %0d want 0", wb_addr);
    end
    for (int a = 0; a < 32; a++) begin
      logic [31:0] want_a;
      logic [31:0] want_b;
      rs_raddr = 5'(a);
      rt_raddr = 5'(31 - a);
      #1;
      want_a = (a == 29) ? 32'd227 : 32'd0;
      want_b = ((31 - a) == 29) ? 32'd227 : 32'd0;
      checks++;
      if (rs_data !== want_a || rt_data !== want_b) begin
        failures++;
        $display("FAIL reset_read a=%0d: got rs=%h rt=%h want rs=%h rt=%h",
                 a, rs_data, rt_data, want_a, want_b);
      end
    end
  endtask

  task automatic test_bypass();
    reg_write = 1'b1;
    wr_sel    = 2'b11;
    rd_addr   = 5'd8;
    rt_addr   = 5'd2;
    wr_data   = 32'hDEAD_BEEF;
    rs_raddr  = 5'd8;
    rt_raddr  = 5'd8;
    tick();
    idle_inputs();
    #1;
    checks++;
    if (wb_valid !== 1'b1 || wb_addr !== 5'd8) begin
      failures++;
      $display("FAIL bypass_stage: got valid=%0b addr=%0d want valid=1 addr=8",
               wb_valid, wb_addr);
    end
    checks++;
    if (rs_data !== 32'hDEAD_BEEF || rt_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL bypass_read: got rs=%h rt=%h want deadbeef", rs_data, rt_data);
    end
    tick();
    tick();
    checks++;
    if (wb_valid !== 1'b0 || rs_data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL array_read: got valid=%0b rs=%h want valid=0 rs=deadbeef",
               wb_valid, rs_data);
    end
  endtask

  task automatic test_special();
    reg_write = 1'b1;
    rt_addr   = 5'd3;
    rd_addr   = 5'd3;
    wr_sel    = 2'b01;
    wr_data   = 32'h100;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_addr !== 5'd29) begin
      failures++;
      $display("FAIL sp_stage: got valid=%0b addr=%0d want valid=1 addr=29",
               wb_valid, wb_addr);
    end
    wr_sel  = 2'b10;
    wr_data = 32'h200;
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_addr !== 5'd31) begin
      failures++;
      $display("FAIL ra_stage: got valid=%0b addr=%0d want valid=1 addr=31",
               wb_valid, wb_addr);
    end
    idle_inputs();
    tick();
    tick();
    rs_raddr = 5'd29;
    rt_raddr = 5'd31;
    #1;
    checks++;
    if (rs_data !== 32'h100 || rt_data !== 32'h200) begin
      failures++;
      $display("FAIL sp_ra_values: got r29=%h r31=%h want 100/200", rs_data, rt_data);
    end
    rs_raddr = 5'd3;
    #1;
    checks++;
    if (rs_data !== 32'd0) begin
      failures++;
      $display("FAIL r3_untouched: got %h want 0", rs_data);
    end
  endtask

  task automatic test_zero();
    reg_write = 1'b1;
    wr_sel    = 2'b00;
    rt_addr   = 5'd0;
    rd_addr   = 5'd7;
    wr_data   = 32'hFFFF;
    rs_raddr  = 5'd0;
    rt_raddr  = 5'd7;
    tick();
    idle_inputs();
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL zero_no_capture: got valid=%0b want 0", wb_valid);
    end
    tick();
    tick();
    checks++;
    if (rs_data !== 32'd0 || rt_data !== 32'd0) begin
      failures++;
      $display("FAIL zero_read: got r0=%h r7=%h want 0/0", rs_data, rt_data);
    end
  endtask

  task automatic test_back_to_back();
    reg_write = 1'b1;
    wr_sel    = 2'b11;
    rd_addr   = 5'd5;
    wr_data   = 32'h1;
    rs_raddr  = 5'd5;
    rt_raddr  = 5'd5;
    tick();
    wr_data = 32'h2;
    tick();
    idle_inputs();
    checks++;
    if (rs_data !== 32'h2 || wb_valid !== 1'b1 || wb_addr !== 5'd5) begin
      failures++;
      $display("FAIL b2b_bypass: got rs=%h valid=%0b addr=%0d want 2/1/5",
               rs_data, wb_valid, wb_addr);
    end
    tick();
    tick();
    checks++;
    if (rs_data !== 32'h2 || rt_data !== 32'h2) begin
      failures++;
      $display("FAIL b2b_settle: got rs=%h rt=%h want 2", rs_data, rt_data);
    end
  endtask

  task automatic test_reset_discard();
    reg_write = 1'b1;
    wr_sel    = 2'b11;
    rd_addr   = 5'd9;
    wr_data   = 32'hAA;
    rs_raddr  = 5'd9;
    rt_raddr  = 5'd29;
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || rs_data !== 32'd0 || rt_data !== 32'd227) begin
      failures++;
      $display("FAIL reset_discard: got valid=%0b r9=%h r29=%h want 0/0/e3",
               wb_valid, rs_data, rt_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reg_write = ($urandom_range(0, 3) != 0);
      wr_sel    = 2'($urandom_range(0, 3));
      rt_addr   = 5'($urandom_range(0, 31));
      rd_addr   = 5'($urandom_range(0, 31));
      wr_data   = $urandom();
      tick();
      // Bias read addresses toward the last destination to exercise bypass.
      rs_raddr  = ($urandom_range(0, 1) != 0) ? exp_addr : 5'($urandom_range(0, 31));
      rt_raddr  = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (wb_valid !== exp_valid || (exp_valid && wb_addr !== exp_addr)) begin
        failures++;
        $display("FAIL rand_stage n=%0d: got valid=%0b addr=%0d want valid=%0b addr=%0d",
                 n, wb_valid, wb_addr, exp_valid, exp_addr);
      end
      checks++;
      if (rs_data !== mem[rs_raddr] || rt_data !== mem[rt_raddr]) begin
        failures++;
        $display("FAIL rand_read n=%0d: got rs[%0d]=%h rt[%0d]=%h want %h/%h",
                 n, rs_raddr, rs_data, rt_raddr, rt_data, mem[rs_raddr], mem[rt_raddr]);
      end
    end
    idle_inputs();
    tick();
    tick();
    for (int a = 0; a < 32; a++) begin
      rs_raddr = 5'(a);
      #1;
      checks++;
      if (rs_data !== mem[a]) begin
        failures++;
        $display("FAIL rand_final a=%0d: got %h want %h", a, rs_data, mem[a]);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    rs_raddr = 5'd0;
    rt_raddr = 5'd0;
    idle_inputs();
    model_reset();
    test_reset();
    test_bypass();
    test_special();
    test_zero();
    test_back_to_back();
    test_reset_discard();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_regfile_wb_port
`default_nettype wire
